// File: rtl/bus_stall_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, FSM states,
// simple-bus widths and the per-bit stall levels.
package bus_stall_ctrl_pkg;

    localparam int BUS_DATA_BUS = 32;
    localparam int BUS_STRB_BUS = 4;

    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/bus_stall_ctrl_stall_encoder.sv
// Priority encoder from the four stall sources to the stall vector;
// the highest pipeline stage requesting a stall wins.
module stall_encoder
    import bus_stall_ctrl_pkg::*;
(
    input  logic       sreq_mem_i,
    input  logic       sreq_ex_i,
    input  logic       sreq_id_i,
    input  logic       sreq_if_i,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (sreq_mem_i)     stall_o = STALL_MEM;
        else if (sreq_ex_i) stall_o = STALL_EX;
        else if (sreq_id_i) stall_o = STALL_ID;
        else if (sreq_if_i) stall_o = STALL_IF;
    end

endmodule

// File: rtl/bus_stall_ctrl.sv
// Pipeline sequencer: arbitrates the single bus master between IF and MEM,
// holds completed results until the owning stage advances, and drives stall.
module bus_stall_ctrl
    import bus_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stallreq_id,
    input  logic                    stallreq_ex,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic [BUS_DATA_BUS-1:0] if_rdata,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [31:0]             mem_addr,
    input  logic [BUS_DATA_BUS-1:0] mem_wdata,
    input  logic [BUS_STRB_BUS-1:0] mem_wstrb,
    output logic [BUS_DATA_BUS-1:0] mem_rdata,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [31:0]             bus_addr,
    output logic [BUS_DATA_BUS-1:0] bus_wdata,
    output logic [BUS_STRB_BUS-1:0] bus_wstrb,
    input  logic                    bus_ready,
    input  logic [BUS_DATA_BUS-1:0] bus_rdata,
    output logic                    bus_err,
    output logic [5:0]              stall
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_e                  state_q;
    logic                    bus_req_q, bus_we_q, bus_err_q;
    logic [31:0]             bus_addr_q, cnt_q;
    logic [BUS_DATA_BUS-1:0] bus_wdata_q, if_rdata_q, mem_rdata_q;
    logic [BUS_STRB_BUS-1:0] bus_wstrb_q;
    logic                    if_done_q, mem_done_q;

    logic                    sreq_if, sreq_mem, timeout_hit, access_end;
    logic [BUS_DATA_BUS-1:0] result_d;
    logic [5:0]              stall_enc;

    assign sreq_if  = if_req & ~if_done_q;
    assign sreq_mem = mem_req & ~mem_done_q;

    stall_encoder u_enc (
        .sreq_mem_i (sreq_mem),
        .sreq_ex_i  (stallreq_ex),
        .sreq_id_i  (stallreq_id),
        .sreq_if_i  (sreq_if),
        .stall_o    (stall_enc)
    );

    // The pipeline must not see a stall while the core is held in reset.
    assign stall = rst ? stall_enc : STALL_NONE;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !bus_ready;
    assign access_end  = bus_ready | timeout_hit;
    // Writes and aborted accesses leave 0 in the holding register.
    assign result_d    = (bus_ready && !bus_we_q) ? bus_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (stall[1] == NOT_STOP) if_done_q  <= 1'b0;
            if (stall[4] == NOT_STOP) mem_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (sreq_mem) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we;
                        bus_addr_q  <= mem_addr;
                        bus_wdata_q <= mem_wdata;
                        bus_wstrb_q <= mem_wstrb;
                        state_q     <= MEM_BUSY;
                    end else if (sreq_if) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr;
                        bus_wdata_q <= '0;
                        bus_wstrb_q <= '0;
                        state_q     <= IF_BUSY;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (access_end) begin
                        bus_req_q <= 1'b0;
                        bus_err_q <= timeout_hit;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        // A flushed requester gets nothing back and no done flag.
                        if (state_q == IF_BUSY && if_req) begin
                            if_rdata_q <= result_d;
                            if_done_q  <= 1'b1;
                        end
                        if (state_q == MEM_BUSY && mem_req) begin
                            mem_rdata_q <= result_d;
                            mem_done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_bus_stall_ctrl.sv
// Directed bench for bus_stall_ctrl with a short timeout; the bridge is
// played by hand-timed bus_ready pulses.
module tb_bus_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, if_rdata, mem_rdata;
    logic [3:0]  mem_wstrb, bus_wstrb;
    logic        bus_req, bus_we, bus_ready, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [5:0]  stall;

    int checks = 0;
    int failures = 0;

    bus_stall_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .bus_err(bus_err), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 0; stallreq_ex = 0;
        if_req = 1; mem_req = 1; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        bus_ready = 0; bus_rdata = 0;
        #1 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h00);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);

        // IF fetch, ready on the 3rd busy cycle
        rst = 1'b1; mem_req = 0; if_addr = 32'hBFC00000;
        #1 chk("if_stall_idle", 32'(stall), 32'h03);
        tick();
        chk("if_bus_req", 32'(bus_req), 32'h1);
        chk("if_bus_addr", bus_addr, 32'hBFC00000);
        chk("if_bus_we", 32'(bus_we), 32'h0);
        chk("if_stall_b1", 32'(stall), 32'h03);
        tick();
        chk("if_stall_b2", 32'(stall), 32'h03);
        bus_ready = 1; bus_rdata = 32'h24010001;
        tick();
        bus_ready = 0;
        chk("if_done_stall", 32'(stall), 32'h00);
        chk("if_rdata", if_rdata, 32'h24010001);
        chk("if_bus_req_off", 32'(bus_req), 32'h0);
        if_req = 0;
        tick();

        // Arbitration: MEM write wins, IF follows after one idle cycle
        if_req = 1; if_addr = 32'hBFC00004;
        mem_req = 1; mem_we = 1; mem_addr = 32'h80000010;
        mem_wdata = 32'hDEADBEEF; mem_wstrb = 4'hF;
        #1 chk("arb_stall", 32'(stall), 32'h1F);
        tick();
        chk("arb_mem_we", 32'(bus_we), 32'h1);
        chk("arb_mem_addr", bus_addr, 32'h80000010);
        chk("arb_mem_wdata", bus_wdata, 32'hDEADBEEF);
        chk("arb_mem_wstrb", 32'(bus_wstrb), 32'hF);
        chk("arb_mem_stall", 32'(stall), 32'h1F);
        bus_ready = 1; bus_rdata = 32'h55555555;
        tick();
        bus_ready = 0;
        chk("arb_mem_rdata", mem_rdata, 32'h0);
        chk("arb_idle_req", 32'(bus_req), 32'h0);
        chk("arb_idle_stall", 32'(stall), 32'h03);
        mem_req = 0; mem_we = 0;
        tick();
        chk("arb_if_req", 32'(bus_req), 32'h1);
        chk("arb_if_addr", bus_addr, 32'hBFC00004);
        chk("arb_if_we", 32'(bus_we), 32'h0);
        chk("arb_if_stall", 32'(stall), 32'h03);

        // IF completes, then MEM stalls the pipe while if_done is held
        bus_ready = 1; bus_rdata = 32'h11112222;
        tick();
        bus_ready = 0;
        mem_req = 1; mem_addr = 32'h80000020;
        #1 chk("hold_stall_mem", 32'(stall), 32'h1F);
        chk("hold_if_rdata0", if_rdata, 32'h11112222);
        tick();
        chk("hold_bus_addr", bus_addr, 32'h80000020);
        chk("hold_bus_we", 32'(bus_we), 32'h0);
        chk("hold_if_rdata1", if_rdata, 32'h11112222);
        bus_ready = 1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ready = 0;
        chk("hold_stall_free", 32'(stall), 32'h00);
        chk("hold_mem_rdata", mem_rdata, 32'hCAFEF00D);
        chk("hold_if_rdata2", if_rdata, 32'h11112222);
        chk("hold_no_refetch", 32'(bus_req), 32'h0);
        if_req = 0; mem_req = 0;
        tick();
        chk("hold_idle_req", 32'(bus_req), 32'h0);

        // Timeout: mem read with no bus_ready
        mem_req = 1; mem_addr = 32'h80000030;
        tick();
        chk("to_req_b1", 32'(bus_req), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("to_err_low", 32'(bus_err), 32'h0);
            chk("to_stall_busy", 32'(stall), 32'h1F);
            tick();
        end
        chk("to_err_pulse", 32'(bus_err), 32'h1);
        chk("to_req_off", 32'(bus_req), 32'h0);
        chk("to_mem_rdata", mem_rdata, 32'h0);
        chk("to_stall", 32'(stall), 32'h00);
        mem_req = 0;
        tick();
        chk("to_err_once", 32'(bus_err), 32'h0);

        // Priority during an IF access
        if_req = 1; if_addr = 32'hBFC00008;
        tick();
        stallreq_ex = 1;
        #1 chk("pri_ex", 32'(stall), 32'h0F);
        stallreq_ex = 0; stallreq_id = 1;
        #1 chk("pri_id", 32'(stall), 32'h07);
        stallreq_id = 0;
        bus_ready = 1; bus_rdata = 32'h0BADF00D;
        tick();
        bus_ready = 0;
        chk("pri_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 0;
        tick();

        // Flush: requester drops mid-access, result discarded
        if_req = 1; if_addr = 32'hBFC0000C;
        tick();
        if_req = 0;
        bus_ready = 1; bus_rdata = 32'h77777777;
        tick();
        bus_ready = 0;
        chk("flush_if_rdata", if_rdata, 32'h0BADF00D);
        chk("flush_stall", 32'(stall), 32'h00);
        // Stray ready in IDLE is ignored
        bus_ready = 1; bus_rdata = 32'h99999999;
        tick();
        bus_ready = 0;
        chk("stray_if_rdata", if_rdata, 32'h0BADF00D);
        chk("stray_mem_rdata", mem_rdata, 32'h0);
        if_req = 1;
        #1 chk("flush_no_done", 32'(stall), 32'h03);
        tick();
        chk("refetch_req", 32'(bus_req), 32'h1);

        // Reset mid-access
        rst = 0;
        #1 chk("midrst_req", 32'(bus_req), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_stall_ctrl.md
Name: bus_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage core. Produces the stall[5:0] vector consumed by every inter-stage register: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- Arbitrates the single simple-bus master port, which feeds the AXI-Lite bridge, between instruction fetch (IF) and data access (MEM).
- Holds each completed bus result until the owning stage advances, and raises stall requests while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256: busy cycles without bus_ready before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- stallreq_id  input  1  load-use hazard request from ID
- stallreq_ex  input  1  multi-cycle ALU request from EX
- if_req  input  1  IF needs a fetch; level, held while stalled
- if_addr  input  32  fetch address
- if_rdata  output  32  held fetch data
- mem_req  input  1  MEM needs a data access; level
- mem_we  input  1  1 = write
- mem_addr  input  32  data address
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte strobes
- mem_rdata  output  32  held load data
- bus_req  output  1  access request to the bridge
- bus_we  output  1  access is a write
- bus_addr  output  32  access address
- bus_wdata  output  32  write data to the bridge
- bus_wstrb  output  4  byte strobes to the bridge
- bus_ready  input  1  single-cycle completion pulse from the bridge
- bus_rdata  input  32  read data, valid with bus_ready
- bus_err  output  1  one-cycle pulse on timeout abort
- stall  output  6  pipeline stall vector

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb = 0.
  - if_rdata, mem_rdata = 0; if_done, mem_done = 0; bus_err = 0; timeout counter = 0.
  - stall forced to 6'b000000.
- Internal requests: sreq_if = if_req & ~if_done; sreq_mem = mem_req & ~mem_done.
- stall is combinational, highest stage wins:
  - sreq_mem: 011111
  - else stallreq_ex: 001111
  - else stallreq_id: 000111
  - else sreq_if: 000011
  - else: 000000
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - If sreq_mem: register mem_* onto bus_*, set bus_req=1, go MEM_BUSY.
  - Else if sreq_if: register if_addr onto bus_addr, set bus_we=0, bus_wstrb=0, bus_req=1, go IF_BUSY.
  - Both requests in the same cycle: MEM wins (older instruction).
  - Latency: request sampled at edge n; bus_req=1 from edge n+1.
- BUSY states:
  - bus_* held stable; the counter increments each cycle.
  - On bus_ready: capture bus_rdata into the owner's holding register (writes capture 0), set the owner's done flag, bus_req=0, clear the counter, go IDLE.
  - Minimum 1 IDLE cycle between accesses.
- Timeout (TIMEOUT_CYCLES>0): when the counter reaches TIMEOUT_CYCLES-1 with no bus_ready:
  - bus_err=1 for exactly one cycle.
  - Holding register <= 0, done set, go IDLE.
  - The pipeline proceeds.
- Done clear:
  - if_done <= 0 on any edge where stall[1]==0 (IF advances).
  - mem_done <= 0 on any edge where stall[4]==0.
  - Holding registers keep their value until overwritten.
- Completion only occurs while the owner is requesting, so its stall bit is 1 and set/clear of done cannot collide in that cycle.
- A requester that drops its req mid-access (flush): the access completes normally, the result is discarded and done is not set.
- A bus_ready seen in IDLE is ignored.
- Reset mid-access: immediate return to IDLE; the bridge handles its own abort.

Decomposition:
- Shared global defines header:
  - stall encodings STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - FSM state encodings.
  - BUS_DATA_BUS and BUS_STRB_BUS widths.
- Reuse the existing STOP/NOT_STOP macros.
- One sub-module: stall_encoder, the purely combinational priority encoder from the four requests to stall[5:0].

Test Plan:
- Reset:
  - Stimulus: rst=0 with if_req=1, mem_req=1.
  - Required: stall=000000, bus_req=0, if_rdata=0, mem_rdata=0.
- IF fetch:
  - Stimulus: release reset; if_req=1, if_addr=0xBFC00000; bridge returns bus_ready on the 3rd busy cycle with bus_rdata=0x24010001.
  - Required: stall=000011 until the completion edge; then stall=000000 and if_rdata=0x24010001.
- Arbitration:
  - Stimulus: if_req and mem_req (write, addr 0x80000010, wdata 0xDEADBEEF, wstrb 0xF) rise together.
  - Required: MEM access issued first with stall=011111; IF access starts after 1 IDLE cycle with stall=000011; mem_rdata=0.
- IF done held under MEM stall:
  - Stimulus: IF completes (rdata 0x11112222) while mem_req later stalls the pipe.
  - Required: if_done held and if_rdata stays 0x11112222 until the first edge with stall[1]=0; no second fetch is issued.
- Timeout (TIMEOUT_CYCLES=4):
  - Stimulus: mem read with bus_ready never asserted.
  - Required: bus_err pulses 1 cycle on the 4th busy cycle; mem_rdata=0; stall drops to 000000; FSM returns to IDLE.
- Priority:
  - Stimulus: stallreq_ex=1 during an IF access.
  - Required: stall=001111.
  - Stimulus: then stallreq_id alone.
  - Required: stall=000111.
